// File: rtl/sum_stationary_pkg.sv
// rtl/sum_stationary_pkg.sv - shared state type and result-width helper for the sum_stationary array and controller
package sum_stationary_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DRAIN
    } ctrl_state_e;

    function automatic int c_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

endpackage

// File: rtl/sum_stationary_ctrl.sv
// rtl/sum_stationary_ctrl.sv - command sequencer for one sum_stationary NxN array
// Clears the array, feeds N operand steps, waits for the array's valid and drains C one row per beat.
module sum_stationary_ctrl
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = c_width(DATA_WIDTH, N),
    parameter int IDX_W        = $clog2(N)
) (
    input  logic                                     clk,
    input  logic                                     reset_ni,
    input  logic                                     cmd_valid_i,
    output logic                                     cmd_ready_o,
    input  logic                                     abort_i,
    output logic                                     op_rd_en_o,
    output logic [IDX_W-1:0]                         op_rd_addr_o,
    input  logic [N-1:0][DATA_WIDTH-1:0]             op_a_i,
    input  logic [N-1:0][DATA_WIDTH-1:0]             op_b_i,
    output logic                                     arr_reset_o,
    output logic                                     arr_valid_o,
    output logic [N-1:0][DATA_WIDTH-1:0]             arr_a_o,
    output logic [N-1:0][DATA_WIDTH-1:0]             arr_b_o,
    input  logic                                     arr_valid_i,
    input  logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0]    arr_c_i,
    output logic                                     res_valid_o,
    input  logic                                     res_ready_i,
    output logic [N-1:0][C_DATA_WIDTH-1:0]           res_row_o,
    output logic [IDX_W-1:0]                         res_idx_o,
    output logic                                     res_last_o,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic                                     error_o
);

    localparam int CNT_W = $clog2(2 * N + 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_arr_rst;
    logic             r_arr_clean;
    logic             r_done;
    logic             r_err;
    logic             w_abort;
    logic             w_err;
    logic             w_hs;
    logic             w_last_hs;

    assign w_abort   = abort_i && (r_state != IDLE);
    assign w_hs      = (r_state == DRAIN) && res_ready_i;
    assign w_last_hs = w_hs && (r_idx == IDX_W'(N - 1));

    // A finished array keeps valid high until it is next reset, so a stray valid only
    // counts as an error once a reset has reached the array since the last feed.
    always_comb begin
        w_err = 1'b0;
        case (r_state)
            IDLE, CLEAR: w_err = arr_valid_i && r_arr_clean;
            FEED:        w_err = arr_valid_i;
            WAIT:        w_err = !arr_valid_i && (r_cnt == CNT_W'(2 * N));
            default:     w_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort || w_err) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (cmd_valid_i && !r_arr_rst) w_state_next = CLEAR;
                CLEAR:   w_state_next = FEED;
                FEED:    if (r_cnt == CNT_W'(N)) w_state_next = WAIT;
                WAIT:    if (arr_valid_i) w_state_next = DRAIN;
                DRAIN:   if (w_last_hs) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_arr_rst   <= 1'b1;
            r_arr_clean <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == FEED || r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_hs && !w_abort) begin
                r_idx <= w_last_hs ? '0 : r_idx + IDX_W'(1);
            end else if (r_state != DRAIN) begin
                r_idx <= '0;
            end
            r_arr_rst <= (w_state_next == CLEAR) || w_abort || w_err;
            if (r_arr_rst) begin
                r_arr_clean <= 1'b1;
            end else if (arr_valid_o) begin
                r_arr_clean <= 1'b0;
            end
            r_done <= w_last_hs && !w_abort;
            r_err  <= r_err || w_err;
        end
    end

    // FEED cycle k issues read k; the buffer answers one cycle later, so the array
    // sees step k-1 in cycle k and the window is cycles 1..N.
    always_comb begin
        cmd_ready_o  = 1'b0;
        busy_o       = (r_state != IDLE);
        op_rd_en_o   = 1'b0;
        op_rd_addr_o = '0;
        arr_valid_o  = 1'b0;
        arr_a_o      = '0;
        arr_b_o      = '0;
        res_valid_o  = 1'b0;
        res_idx_o    = '0;
        res_row_o    = '0;
        res_last_o   = 1'b0;
        case (r_state)
            IDLE: cmd_ready_o = !r_arr_rst;
            FEED: begin
                if (r_cnt < CNT_W'(N)) begin
                    op_rd_en_o   = 1'b1;
                    op_rd_addr_o = r_cnt[IDX_W-1:0];
                end
                if (r_cnt != '0) begin
                    arr_valid_o = 1'b1;
                    arr_a_o     = op_a_i;
                    arr_b_o     = op_b_i;
                end
            end
            DRAIN: begin
                res_valid_o = 1'b1;
                res_idx_o   = r_idx;
                res_row_o   = arr_c_i[r_idx];
                res_last_o  = (r_idx == IDX_W'(N - 1));
            end
            default: ;
        endcase
    end

    assign arr_reset_o = r_arr_rst;
    assign done_o      = r_done;
    assign error_o     = r_err;

endmodule

// File: tb/tb_sum_stationary_ctrl.sv
// tb/tb_sum_stationary_ctrl.sv - table-driven and randomized self-checking bench for sum_stationary_ctrl
module tb_sum_stationary_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 2 * DW + $clog2(N);
    localparam int IW  = $clog2(N);
    localparam int LAT = 3 * N + 2;

    logic clk = 1'b0, reset_ni = 1'b0, cmd_valid_i = 1'b0, abort_i = 1'b0, res_ready_i = 1'b0;
    logic cmd_ready_o, op_rd_en_o, arr_reset_o, arr_valid_o, arr_valid_i;
    logic res_valid_o, res_last_o, busy_o, done_o, error_o;
    logic [IW-1:0] op_rd_addr_o, res_idx_o;
    logic [N-1:0][DW-1:0] op_a_i = '0, op_b_i = '0, arr_a_o, arr_b_o;
    logic [N-1:0][N-1:0][CW-1:0] arr_c_i = '0;
    logic [N-1:0][CW-1:0] res_row_o;

    int A [N][N];
    int B [N][N];
    int expc [N][N];
    int m_beats = 0, m_timer = 0;
    logic m_valid = 1'b0, force_v = 1'b0, block_v = 1'b0;
    int cyc = 0, n_checks = 0, n_err = 0;

    typedef struct {
        int a_kind;
        int b_kind;
        int stall;
        int c00;
        int c33;
    } vec_t;
    vec_t vecs [3];

    sum_stationary_ctrl #(.DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW), .IDX_W(IW)) dut (
        .clk(clk), .reset_ni(reset_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .abort_i(abort_i), .op_rd_en_o(op_rd_en_o), .op_rd_addr_o(op_rd_addr_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .arr_reset_o(arr_reset_o), .arr_valid_o(arr_valid_o),
        .arr_a_o(arr_a_o), .arr_b_o(arr_b_o), .arr_valid_i(arr_valid_i), .arr_c_i(arr_c_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_row_o(res_row_o),
        .res_idx_o(res_idx_o), .res_last_o(res_last_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer: registered read of A column k and B row k.
    always @(posedge clk) begin
        if (op_rd_en_o) begin
            for (int i = 0; i < N; i++) begin
                op_a_i[i] <= DW'(A[i][op_rd_addr_o]);
                op_b_i[i] <= DW'(B[op_rd_addr_o][i]);
            end
        end
    end

    // Array stand-in: accumulates outer products, raises valid 2N-1 clocks after the last step.
    assign arr_valid_i = force_v | (m_valid & ~block_v);
    always @(posedge clk) begin
        if (arr_reset_o) begin
            arr_c_i <= '0; m_beats <= 0; m_timer <= 0; m_valid <= 1'b0;
        end else if (arr_valid_o) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    arr_c_i[i][j] <= arr_c_i[i][j] + CW'(arr_a_o[i]) * CW'(arr_b_o[j]);
            m_beats <= m_beats + 1;
            if (m_beats == N - 1) m_timer <= 2 * N - 2;
        end else if (m_timer == 1) begin
            m_valid <= 1'b1; m_timer <= 0;
        end else if (m_timer > 1) begin
            m_timer <= m_timer - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int a_kind, input int b_kind);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (a_kind == 0) ? int'(i == j) : (a_kind == 1) ? 255 : int'($urandom_range(0, 255));
                B[i][j] = (b_kind == 0) ? i * N + j : (b_kind == 1) ? 255 : int'($urandom_range(0, 255));
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                expc[i][j] = 0;
                for (int k = 0; k < N; k++) expc[i][j] += A[i][k] * B[k][j];
            end
    endtask

    task automatic wait_ready();
        for (int t = 0; t < 50 && !cmd_ready_o; t++) @(negedge clk);
        check("cmd_ready_wait", cmd_ready_o, 1);
    endtask

    task automatic start_cmd(output int c0);
        wait_ready();
        cmd_valid_i = 1'b1;
        c0 = cyc;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60 && !res_valid_o; t++) @(negedge clk);
        check("drain_reached", res_valid_o, 1);
    endtask

    // cmd_valid_i is held high for the whole job to show it is never accepted while busy.
    task automatic run_job(input int stall, input logic exp_err,
                           output logic [CW-1:0] cap00, output logic [CW-1:0] cap33);
        int c0, d, beats, first, pulses, nvalid, bad_ready, gate_bad, done_seen;
        int pat [4] = '{1, 0, 0, 1};
        logic rdy;
        cap00 = '0; cap33 = '0;
        wait_ready();
        cmd_valid_i = 1'b1;
        c0 = cyc;
        d = 0; beats = 0; first = -1; pulses = 0; nvalid = 0; bad_ready = 0; gate_bad = 0; done_seen = 0;
        for (int t = 0; t < 120 && done_seen == 0; t++) begin
            @(negedge clk);
            res_ready_i = 1'b0;
            if (arr_reset_o) pulses++;
            if (arr_valid_o) nvalid++;
            else if (arr_a_o != '0 || arr_b_o != '0) gate_bad++;
            if (busy_o && cmd_ready_o) bad_ready++;
            if (done_o) begin
                done_seen = 1;
            end else if (res_valid_o && beats >= N) begin
                check("res_valid_after_last", res_valid_o, 0);
            end else if (res_valid_o) begin
                if (first < 0) first = cyc - c0;
                check("res_idx", res_idx_o, beats);
                check("res_last", res_last_o, beats == N - 1);
                for (int j = 0; j < N; j++) check("res_row", res_row_o[j], expc[beats][j]);
                if (beats == 0) cap00 = res_row_o[0];
                if (beats == N - 1) cap33 = res_row_o[N-1];
                rdy = (stall == 0) ? 1'b1 : (stall == 1) ? pat[d % 4] != 0 : 1'($urandom_range(0, 1));
                d++;
                res_ready_i = rdy;
                if (rdy) begin
                    beats++;
                    if (beats == N) cmd_valid_i = 1'b0;
                end
            end
        end
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b0;
        check("done_seen", done_seen, 1);
        check("first_valid_latency", first, LAT);
        check("beats", beats, N);
        check("arr_valid_cycles", nvalid, N);
        check("arr_data_gated", gate_bad, 0);
        check("cmd_ready_while_busy", bad_ready, 0);
        check("arr_reset_pulses", pulses, 1);
        check("error_state", error_o, exp_err);
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        check("idle_ready", cmd_ready_o, 1);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c0, bad;
        logic [CW-1:0] c00, c33;

        vecs[0] = '{0, 0, 0, 0, 15};
        vecs[1] = '{1, 1, 0, 260100, 260100};
        vecs[2] = '{0, 0, 1, 0, 15};

        @(negedge clk);
        check("rst_arr_reset", arr_reset_o, 1);
        check("rst_cmd_ready", cmd_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_error", error_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rd_en", op_rd_en_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        reset_ni = 1'b1;
        @(negedge clk);
        check("post_rst_arr_reset", arr_reset_o, 0);
        check("post_rst_cmd_ready", cmd_ready_o, 1);

        for (int v = 0; v < 3; v++) begin
            fill(vecs[v].a_kind, vecs[v].b_kind);
            run_job(vecs[v].stall, 1'b0, c00, c33);
            check("table_c00", c00, vecs[v].c00);
            check("table_c33", c33, vecs[v].c33);
        end

        for (int r = 0; r < 6; r++) begin
            fill(2, 2);
            run_job(int'($urandom_range(0, 2)), 1'b0, c00, c33);
        end

        // Abort in FEED cycle 2, then a clean job.
        fill(2, 2);
        start_cmd(c0);
        repeat (3) @(negedge clk);
        check("abort_at_feed", op_rd_en_o, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_arr_reset", arr_reset_o, 1);
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            if (done_o || res_valid_o) bad++;
            @(negedge clk);
        end
        check("abort_no_done", bad, 0);
        run_job(0, 1'b0, c00, c33);

        // Abort beats a same-cycle result handshake.
        fill(2, 2);
        start_cmd(c0);
        wait_drain();
        res_ready_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        abort_i = 1'b0;
        check("abort_drain_busy", busy_o, 0);
        check("abort_drain_done", done_o, 0);
        check("abort_drain_arr_reset", arr_reset_o, 1);
        @(negedge clk);
        check("abort_drain_done_late", done_o, 0);

        // WAIT timeout with the array valid suppressed.
        fill(2, 2);
        block_v = 1'b1;
        start_cmd(c0);
        while (cyc < c0 + 15) @(negedge clk);
        check("timeout_not_yet", error_o, 0);
        check("timeout_still_wait", busy_o, 1);
        @(negedge clk);
        check("timeout_error", error_o, 1);
        check("timeout_idle", busy_o, 0);
        check("timeout_arr_reset", arr_reset_o, 1);
        block_v = 1'b0;
        repeat (5) @(negedge clk);
        check("error_sticky", error_o, 1);
        run_job(0, 1'b1, c00, c33);

        reset_ni = 1'b0;
        @(negedge clk);
        check("rst_clears_error", error_o, 0);
        reset_ni = 1'b1;
        @(negedge clk);

        // Array valid forced during FEED.
        start_cmd(c0);
        repeat (2) @(negedge clk);
        force_v = 1'b1;
        @(negedge clk);
        force_v = 1'b0;
        check("force_error", error_o, 1);
        check("force_idle", busy_o, 0);
        check("force_arr_reset", arr_reset_o, 1);

        // Async reset mid-DRAIN with cmd_valid_i held.
        fill(2, 2);
        wait_ready();
        cmd_valid_i = 1'b1;
        wait_drain();
        reset_ni = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_arr_reset", arr_reset_o, 1);
        check("mid_rst_error", error_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_cmd_ready", cmd_ready_o, 0);
        check("mid_rst_res_idx", res_idx_o, 0);
        @(negedge clk);
        check("mid_rst_hold_busy", busy_o, 0);
        check("mid_rst_hold_arr_reset", arr_reset_o, 1);
        cmd_valid_i = 1'b0;
        reset_ni = 1'b1;
        @(negedge clk);
        check("mid_rst_release", arr_reset_o, 0);
        run_job(2, 1'b0, c00, c33);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_stationary_ctrl.md
Name: sum_stationary_ctrl

Overview:
Sequencer for one sum_stationary NxN systolic array. On each accepted command it clears the array, streams N operand steps from an external operand buffer into the array, and waits for the array's valid. It then drains the C matrix one row per beat over a valid/ready result stream. It sits between the operand buffer / host command path and the array; the array's own ports are driven only by this block.

Parameters:
DATA_WIDTH, 8, operand element width
N, 4, matrix dimension (N >= 2)
C_DATA_WIDTH, 2*DATA_WIDTH+$clog2(N), result element width (matches array)
IDX_W, $clog2(N), operand address / row index width

Ports:
clk  in  1  clock
reset_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  start request
cmd_ready_o  out  1  high only in IDLE
abort_i  in  1  synchronous abort of the running job
op_rd_en_o  out  1  operand buffer read strobe
op_rd_addr_o  out  IDX_W  operand step k
op_a_i  in  DATA_WIDTH x N  A column k, returned 1 cycle after op_rd_en_o
op_b_i  in  DATA_WIDTH x N  B row k, returned 1 cycle after op_rd_en_o
arr_reset_o  out  1  array synchronous active-high reset
arr_valid_o  out  1  array valid_i
arr_a_o  out  DATA_WIDTH x N  array a_i
arr_b_o  out  DATA_WIDTH x N  array b_i
arr_valid_i  in  1  array valid_o
arr_c_i  in  C_DATA_WIDTH x N x N  array c_o
res_valid_o  out  1  result row valid
res_ready_i  in  1  consumer ready
res_row_o  out  C_DATA_WIDTH x N  arr_c_i[res_idx_o], combinational mux
res_idx_o  out  IDX_W  row index
res_last_o  out  1  res_idx_o == N-1 while res_valid_o
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse after the last row handshake
error_o  out  1  sticky protocol error, cleared only by reset

Behaviour:
- Reset values: state IDLE, arr_reset_o=1, error_o=0, all other outputs 0. arr_reset_o drops to 0 on the first clock after reset release.
- FSM states: IDLE, CLEAR, FEED, WAIT, DRAIN.
- IDLE:
  - cmd_ready_o=1.
  - cmd_valid_i&cmd_ready_o -> CLEAR.
- CLEAR: one cycle; arr_reset_o=1; step counter k=0 -> FEED.
- FEED: lasts N+1 cycles.
  - Cycles 0..N-1: op_rd_en_o=1, op_rd_addr_o=k, k++.
  - Cycles 1..N: arr_valid_o=1; arr_a_o/arr_b_o are the registered op_a_i/op_b_i.
  - The array sees exactly N contiguous valid cycles. arr_a_o/arr_b_o are 0 when arr_valid_o=0.
  - After cycle N -> WAIT.
- WAIT: array self-runs 2N-2 cycles.
  - arr_valid_i=1 -> DRAIN with res_idx_o=0.
  - A timeout counter in WAIT exceeding 2N cycles -> error_o=1, go to IDLE, pulse arr_reset_o.
- DRAIN:
  - res_valid_o=1.
  - On res_valid_o&res_ready_i: res_idx_o++.
  - On the handshake at idx N-1: go to IDLE, done_o=1 the next cycle.
  - res_ready_i low: hold row/idx indefinitely; array outputs stay stable because the array enable is off while it is valid.
- Latency, cmd handshake at cycle 0: CLEAR at 1, FEED 2..N+2, arr_valid_i high at 3N+1, first res_valid_o at 3N+2. For N=4 that is cycle 14.
- abort_i in a non-IDLE state:
  - Next state IDLE; one-cycle arr_reset_o pulse; no done_o.
  - Abort wins over a same-cycle result handshake, so that beat is not counted.
  - Ignored in IDLE.
- arr_valid_i=1 in IDLE (after the array reset has taken effect), CLEAR or FEED: error_o=1, go to IDLE.
- cmd_valid_i outside IDLE is ignored (not accepted).
- Async reset mid-operation: immediate return to reset values. arr_reset_o=1 holds the array in reset on every clock during reset.
- No arithmetic is performed; widths pass through unchanged.

Decomposition:
- sum_stationary_pkg: ctrl_state_e enum (IDLE, CLEAR, FEED, WAIT, DRAIN) and a c_width(DATA_WIDTH, N) function, shared with the array.
- Single module, no sub-module. The feed register stage and the row mux are inline.

Test Plan:
- N=4, A=identity, B[i][j]=i*4+j, res_ready_i=1 -> rows 0..3 equal B; first res_valid_o at cycle 14; res_last_o on idx 3; done_o one cycle later.
- A all 255, B all 255, N=4 -> every element 260100 (fits C_DATA_WIDTH=18); no error_o.
- res_ready_i toggled 1-0-0-1 during drain -> res_row_o/res_idx_o stable while stalled; exactly 4 beats, in order 0..3.
- abort_i in FEED cycle 2 -> arr_reset_o pulse, IDLE, no done_o; new command then yields a correct result.
- Force arr_valid_i=1 during FEED -> error_o=1 sticky, IDLE. Hold arr_valid_i=0 in WAIT -> error_o after 2N+1 cycles.
- Deassert reset_ni mid-DRAIN -> all outputs at reset values immediately, arr_reset_o=1; cmd_valid_i during busy is never accepted.
